// File: rtl/lcd_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : lcd_seq_pkg
// Brief   : Shared types, state encodings and decode helpers for the LCD sequencer
// Rev     : 1.0  initial release
// ============================================================================
package lcd_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t SETUP = 3'd1;
  localparam state_t E_HI  = 3'd2;
  localparam state_t HOLD  = 3'd3;
  localparam state_t EXEC  = 3'd4;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  // Clear and Home (0x02/0x03, bit0 is don't-care) need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : lcd_cmd_fifo
// Brief  : Small synchronous FIFO; full/empty derived from an occupancy counter
// Rev    : 1.0  initial release
// ============================================================================
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == (PTR_W+1)'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : lcd_cmd_sequencer
// Brief  : Avalon-MM slave that queues HD44780 bytes and generates timed E cycles
// Rev    : 1.0  initial release
// ============================================================================
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int SETUP_CYC      = 3,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data
);

  localparam int MAX_WAIT = (LONG_WAIT_CYC > SHORT_WAIT_CYC) ? LONG_WAIT_CYC : SHORT_WAIT_CYC;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_ehigh_ld = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_short_ld = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] c_long_ld  = CNT_W'(LONG_WAIT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic [7:0]       r_lcd_data;
  logic             r_long;
  logic [7:0]       r_readdata;

  logic             w_wr_target;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [LVL_W-1:0] w_level;
  logic [31:0]      w_level_ext;
  logic [2:0]       w_level_sat;
  logic             w_busy;
  logic [7:0]       w_status;
  lcd_entry_t       w_head;
  logic [8:0]       w_fifo_dout;

  // Only command and data addresses take writes; bit0 marks the read-only slots
  assign w_wr_target = write && !address[0];
  assign w_push      = w_wr_target && !w_full;
  assign waitrequest = w_wr_target && w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_head      = lcd_entry_t'(w_fifo_dout);

  lcd_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     ({address[1], writedata}),
    .dout    (w_fifo_dout),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  assign w_level_ext = {{(32-LVL_W){1'b0}}, w_level};
  assign w_level_sat = (w_level_ext > 32'd7) ? 3'd7 : w_level_ext[2:0];
  assign w_busy      = (r_state != IDLE) || !w_empty;
  assign w_status    = {3'b000, w_level_sat, w_full, w_busy};

  // Each timed state loads N-1 on entry and leaves when the counter hits zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
      r_long     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_state    <= SETUP;
            r_cnt      <= c_setup_ld;
            r_lcd_rs   <= w_head.rs;
            r_lcd_data <= w_head.data;
            r_long     <= is_long_cmd(w_head.rs, w_head.data);
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state <= E_HI;
            r_cnt   <= c_ehigh_ld;
            r_lcd_e <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        E_HI: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            r_cnt   <= c_hold_ld;
            r_lcd_e <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= EXEC;
            r_cnt   <= r_long ? c_long_ld : c_short_ld;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_lcd_e <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 8'h00;
    end else begin
      r_readdata <= (read && (address == ADDR_STATUS)) ? w_status : 8'h00;
    end
  end

  assign readdata = r_readdata;
  assign LCD_E    = r_lcd_e;
  assign LCD_RS   = r_lcd_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_cmd_sequencer
// Brief  : Directed + random bench with a timeline model of the LCD sequencer
// Rev    : 1.0  initial release
// ============================================================================
module tb_lcd_cmd_sequencer;

  localparam int SETUP = 3;
  localparam int EHI   = 12;
  localparam int HOLD  = 2;
  localparam int SHORT = 20;
  localparam int LONG  = 200;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       waitrequest;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_data;

  lcd_cmd_sequencer #(
    .SETUP_CYC      (SETUP),
    .E_HIGH_CYC     (EHI),
    .HOLD_CYC       (HOLD),
    .SHORT_WAIT_CYC (SHORT),
    .LONG_WAIT_CYC  (LONG),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_data    (LCD_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: per accepted byte, its accept/pop/E-rise/exec-end cycles
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   pop_q[$];
  int   endx_q[$];
  int   rise_log[$];
  bit   have_prev = 0;
  int   last_rise = 0;
  int   last_w    = 0;
  int   last_end  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int level_at(input int c);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] < c) n++;
    foreach (pop_q[i]) if (pop_q[i] < c) n--;
    return n;
  endfunction

  function automatic logic [7:0] status_at(input int c);
    int  lvl = level_at(c);
    bit  busy = (lvl > 0);
    foreach (pop_q[i]) if ((pop_q[i] < c) && (c <= endx_q[i])) busy = 1;
    return {3'b000, 3'(lvl > 7 ? 7 : lvl), (lvl == DEPTH), busy};
  endfunction

  task automatic model_accept(input int c, input logic rs, input logic [7:0] d);
    int   r, w;
    exp_t e;
    r = c + 2 + SETUP;
    if (have_prev && (last_rise + EHI + HOLD + last_w + 1 + SETUP > r))
      r = last_rise + EHI + HOLD + last_w + 1 + SETUP;
    w = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LONG : SHORT;
    acc_q.push_back(c);
    pop_q.push_back(r - SETUP - 1);
    endx_q.push_back(r + EHI + HOLD + w - 1);
    e.rs = rs; e.d = d; e.rise = r;
    exp_q.push_back(e);
    have_prev = 1; last_rise = r; last_w = w;
    last_end = r + EHI + HOLD + w - 1;
  endtask

  task automatic model_clear();
    exp_q.delete(); acc_q.delete(); pop_q.delete(); endx_q.delete();
    have_prev = 0; last_rise = 0; last_w = 0; last_end = 0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    logic exp_wait;
    int   n;
    address = a; writedata = d; write = 1'b1; n = 0;
    forever begin
      @(negedge clk);
      exp_wait = !a[0] && (level_at(cyc) >= DEPTH);
      chk("waitrequest", {31'd0, waitrequest}, {31'd0, exp_wait});
      if (!exp_wait) break;
      n++;
      if (n > 1000) begin
        chk("write_stall_bound", n, 1000);
        break;
      end
    end
    if (!a[0]) model_accept(cyc, a[1], d);
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] obs);
    logic [7:0] expv;
    address = a; read = 1'b1;
    @(negedge clk);
    expv = (a == 2'd1) ? status_at(cyc) : 8'h00;
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    obs = readdata;
    chk("readdata", {24'd0, obs}, {24'd0, expv});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int tgt = last_end + 4;
    while (cyc < tgt) @(posedge clk);
    #1;
  endtask

  // Panel-side monitor: E timing, bus stability and byte order
  initial begin : monitor
    logic       prev_e;
    logic [8:0] prev_bus, bus;
    int         chg_c, fall_c, rise_c;
    exp_t       e;
    prev_e = 1'b0; prev_bus = 9'd0; chg_c = 0; fall_c = -1000; rise_c = 0;
    forever begin
      @(negedge clk);
      bus = {LCD_RS, LCD_data};
      if (!reset_n) begin
        prev_e = 1'b0; prev_bus = bus; chg_c = cyc; fall_c = -1000;
      end else begin
        if (bus !== prev_bus) begin
          chk("bus_hold_after_fall", {31'd0, (cyc - fall_c) >= HOLD}, 32'd1);
          if (exp_q.size() > 0) chk("bus_change_cycle", cyc, exp_q[0].rise - SETUP);
          else chk("bus_change_without_byte", 32'd0, 32'd1);
          chg_c = cyc;
        end
        if (LCD_E && !prev_e) begin
          rise_log.push_back(cyc);
          rise_c = cyc;
          chk("e_rise_expected", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("e_rise_cycle", cyc, e.rise);
            chk("lcd_rs", {31'd0, LCD_RS}, {31'd0, e.rs});
            chk("lcd_data", {24'd0, LCD_data}, {24'd0, e.d});
            chk("setup_min", {31'd0, (cyc - chg_c) >= SETUP}, 32'd1);
            chk("lcd_rw", {31'd0, LCD_RW}, 32'd0);
          end
        end
        if (!LCD_E && prev_e) begin
          chk("e_high_width", cyc - rise_c, EHI);
          fall_c = cyc;
        end
        prev_e = LCD_E; prev_bus = bus;
      end
    end
  end

  initial begin : stim
    logic [7:0] obs;
    logic [1:0] a;
    logic [7:0] d;
    int         n, sel;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd_e", {31'd0, LCD_E}, 32'd0);
    chk("rst_lcd_rs", {31'd0, LCD_RS}, 32'd0);
    chk("rst_lcd_data", {24'd0, LCD_data}, 32'd0);
    chk("rst_readdata", {24'd0, readdata}, 32'd0);
    chk("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Single data byte; status busy mid-exec, then idle
    do_write(2'd2, 8'h41);
    idle(SETUP + EHI + HOLD + 6);
    do_read(2'd1, obs);
    drain();
    do_read(2'd1, obs);
    chk("status_idle", {24'd0, obs}, 32'h00);

    // Clear followed by data: long gap between E rises
    do_write(2'd0, 8'h01);
    do_write(2'd2, 8'h42);
    drain();
    chk("gap_long", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 218);

    // Function-set followed by data: short gap
    do_write(2'd0, 8'h38);
    do_write(2'd2, 8'h43);
    drain();
    chk("gap_short", rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2], 38);

    // Back-to-back burst deep enough to fill the FIFO and stall
    for (int i = 0; i < 6; i++) do_write((i % 2 == 0) ? 2'd2 : 2'd0, 8'h50 + 8'(i));
    drain();

    // Three bytes queued while the first one executes
    do_write(2'd2, 8'h61);
    n = 0;
    while (!LCD_E && n < 100) begin @(negedge clk); n++; end
    chk("e_seen_exec_test", {31'd0, LCD_E}, 32'd1);
    idle(EHI + HOLD + 3);
    do_write(2'd2, 8'h62);
    do_write(2'd2, 8'h63);
    do_write(2'd0, 8'h0C);
    do_read(2'd1, obs);
    chk("status_3_queued", {24'd0, obs}, 32'h0D);
    drain();

    // Writes to read-only slots are dropped; reads of non-status slots give 0
    do_write(2'd1, 8'hA5);
    do_write(2'd3, 8'h5A);
    do_read(2'd0, obs);
    do_read(2'd3, obs);
    do_read(2'd2, obs);
    do_read(2'd1, obs);
    idle(50);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      a = (sel < 5) ? 2'd0 : (sel < 9) ? 2'd2 : (($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3);
      sel = $urandom_range(0, 9);
      d = (sel == 0) ? 8'h01 : (sel == 1) ? 8'h02 : (sel == 2) ? 8'h03 : 8'($urandom_range(0, 255));
      do_write(a, d);
      if ($urandom_range(0, 4) == 0) do_read(2'($urandom_range(0, 3)), obs);
      idle($urandom_range(0, 30));
    end
    drain();
    do_read(2'd1, obs);

    // Asynchronous reset in the middle of an E pulse with bytes still queued
    do_write(2'd2, 8'h55);
    do_write(2'd0, 8'h38);
    do_write(2'd2, 8'h56);
    n = 0;
    while (!LCD_E && n < 200) begin @(negedge clk); n++; end
    chk("e_seen_before_reset", {31'd0, LCD_E}, 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("e_async_drop", {31'd0, LCD_E}, 32'd0);
    model_clear();
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_read(2'd1, obs);
    chk("status_after_reset", {24'd0, obs}, 32'h00);
    idle(300);
    do_read(2'd1, obs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
